// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles,
// redirect flushes and a multi-cycle multiply stall FSM with perf counters.
module hazard_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       reg_read_addr1_d,
    input  logic [4:0]       reg_read_addr2_d,
    input  logic [4:0]       reg_read_addr1_e,
    input  logic [4:0]       reg_read_addr2_e,
    input  logic [4:0]       reg_write_addr_e,
    input  logic             reg_write_en_e,
    input  logic             dmem_read_en_e,
    input  logic             mul_en_e,
    input  logic             branch_taken_e,
    input  logic [4:0]       reg_write_addr_m,
    input  logic             reg_write_en_m,
    input  logic [4:0]       reg_write_addr_w,
    input  logic             reg_write_en_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_fd,
    output logic             pipe_flush,
    output logic [1:0]       fwd_sel1_e,
    output logic [1:0]       fwd_sel2_e,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {IDLE, MUL_WAIT} state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             mul_busy_q;
    logic             mul_done_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic idle;
    logic luse;
    logic mul_start;
    logic stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_en_m && reg_write_addr_m != 5'd0 && reg_write_addr_m == rs)
            return 2'b10;
        if (reg_write_en_w && reg_write_addr_w != 5'd0 && reg_write_addr_w == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_sel1_e = fwd_sel(reg_read_addr1_e);
        fwd_sel2_e = fwd_sel(reg_read_addr2_e);
    end

    assign idle = (state_q == IDLE);
    assign luse = dmem_read_en_e && reg_write_en_e && reg_write_addr_e != 5'd0 &&
                  (reg_write_addr_e == reg_read_addr1_d ||
                   reg_write_addr_e == reg_read_addr2_d);

    // A redirect squashes the execute instruction, so it cannot start a multiply
    assign mul_start = idle && mul_en_e && !branch_taken_e && !reset;
    assign stall     = !reset && (!idle || mul_start || (luse && !branch_taken_e));

    assign stall_f      = stall;
    assign stall_d      = stall;
    assign flush_fd     = !reset && branch_taken_e;
    assign pipe_flush   = stall || flush_fd;
    assign mul_busy     = mul_busy_q;
    assign mul_done     = mul_done_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mul_busy_q  <= 1'b0;
            mul_done_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush_fd);
            unique case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        state_q    <= MUL_WAIT;
                        cnt_q      <= 4'(MUL_LATENCY - 1);
                        mul_busy_q <= 1'b1;
                        mul_done_q <= (MUL_LATENCY == 2);
                    end
                end
                MUL_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q    <= IDLE;
                        mul_busy_q <= 1'b0;
                        mul_done_q <= 1'b0;
                    end else begin
                        mul_busy_q <= 1'b1;
                        mul_done_q <= (cnt_q == 4'd2);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks plus a randomized run
// compared every cycle against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

    localparam int LAT = 3;
    localparam int CW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic en_e, dmem, mul_en, br, en_m, en_w;
    logic stall_f, stall_d, flush_fd, pipe_flush, mul_busy, mul_done;
    logic [1:0] fwd1, fwd2;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .reg_read_addr1_d(rs1_d), .reg_read_addr2_d(rs2_d),
        .reg_read_addr1_e(rs1_e), .reg_read_addr2_e(rs2_e),
        .reg_write_addr_e(rd_e), .reg_write_en_e(en_e),
        .dmem_read_en_e(dmem), .mul_en_e(mul_en),
        .branch_taken_e(br),
        .reg_write_addr_m(rd_m), .reg_write_en_m(en_m),
        .reg_write_addr_w(rd_w), .reg_write_en_w(en_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_fd(flush_fd),
        .pipe_flush(pipe_flush), .fwd_sel1_e(fwd1), .fwd_sel2_e(fwd2),
        .mul_busy(mul_busy), .mul_done(mul_done),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a multiply started in cycle s occupies cycles s+1..s+LAT-1
    int cyc = 0;
    int mstart = 0;
    bit mact = 1'b0;
    bit mvalid = 1'b0;
    logic [CW-1:0] mst = '0;
    logic [CW-1:0] mfl = '0;

    function automatic bit in_mul();
        int d;
        d = cyc - mstart;
        return mact && d >= 1 && d <= LAT - 1;
    endfunction

    function automatic bit m_start();
        return !in_mul() && mul_en && !br && !reset;
    endfunction

    function automatic bit m_stall();
        bit lu;
        lu = dmem && en_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        return !reset && (in_mul() || m_start() || (lu && !br));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (en_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (en_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mact   <= 1'b0;
            mst    <= '0;
            mfl    <= '0;
            mvalid <= 1'b1;
        end else if (mvalid) begin
            if (m_start()) begin
                mact   <= 1'b1;
                mstart <= cyc;
            end
            mst <= mst + CW'(m_stall());
            mfl <= mfl + CW'(br);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_stall_f", stall_f, m_stall());
            chk("m_stall_d", stall_d, m_stall());
            chk("m_flush_fd", flush_fd, !reset && br);
            chk("m_pipe_flush", pipe_flush, m_stall() || (!reset && br));
            chk("m_fwd1", fwd1, m_fwd(rs1_e));
            chk("m_fwd2", fwd2, m_fwd(rs2_e));
            chk("m_busy", mul_busy, in_mul());
            chk("m_done", mul_done, in_mul() && (cyc - mstart == LAT - 1));
            chk("m_stall_cycles", stall_cycles, mst);
            chk("m_flush_events", flush_events, mfl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {en_e, dmem, mul_en, br, en_m, en_w} = '0;
    endtask

    task automatic do_reset();
        clear();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_luse();
        dmem  = 1'b1;
        en_e  = 1'b1;
        rd_e  = 5'd7;
        rs2_d = 5'd7;
    endtask

    initial begin
        clear();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_flush_events", flush_events, 0);
        chk("rst_busy", mul_busy, 0);

        rs1_e = 5'd5; rd_m = 5'd5; en_m = 1'b1; rd_w = 5'd5; en_w = 1'b1;
        #1 chk("fwd_mem_wins", fwd1, 2'b10);
        en_m = 1'b0;
        #1 chk("fwd_wb", fwd1, 2'b01);
        rs1_e = 5'd0; rd_m = 5'd0; en_m = 1'b1;
        #1 chk("fwd_x0", fwd1, 2'b00);
        tick();
        clear();

        set_luse();
        #1;
        chk("luse_stall_f", stall_f, 1);
        chk("luse_stall_d", stall_d, 1);
        chk("luse_bubble", pipe_flush, 1);
        tick();
        clear();
        #1;
        chk("luse_once", stall_d, 0);
        chk("luse_count", stall_cycles, 1);

        set_luse();
        br = 1'b1;
        #1;
        chk("redir_flush_fd", flush_fd, 1);
        chk("redir_bubble", pipe_flush, 1);
        chk("redir_no_stall", stall_d, 0);
        tick();
        clear();
        #1;
        chk("redir_flush_cnt", flush_events, 1);
        chk("redir_stall_cnt", stall_cycles, 1);

        do_reset();
        mul_en = 1'b1;
        #1;
        chk("mul_c0_stall", stall_d, 1);
        chk("mul_c0_busy", mul_busy, 0);
        tick();
        mul_en = 1'b0;
        #1;
        chk("mul_c1_busy", mul_busy, 1);
        chk("mul_c1_done", mul_done, 0);
        chk("mul_c1_stall", stall_d, 1);
        tick();
        #1;
        chk("mul_c2_busy", mul_busy, 1);
        chk("mul_c2_done", mul_done, 1);
        chk("mul_c2_stall", stall_f, 1);
        tick();
        #1;
        chk("mul_c3_busy", mul_busy, 0);
        chk("mul_c3_done", mul_done, 0);
        chk("mul_c3_stall", stall_d, 0);
        chk("mul_stall_cnt", stall_cycles, 3);

        do_reset();
        mul_en = 1'b1;
        tick();
        mul_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstmul_busy", mul_busy, 0);
        chk("rstmul_stall", stall_d, 0);
        chk("rstmul_done", mul_done, 0);
        chk("rstmul_cnt", stall_cycles, 0);
        tick();

        do_reset();
        set_luse();
        repeat (17) tick();
        clear();
        #1 chk("wrap_cnt", stall_cycles, 1);
        tick();

        repeat (3000) begin
            reset  = ($urandom_range(199) == 0);
            mul_en = ($urandom_range(15) == 0);
            br     = !mul_en && ($urandom_range(9) == 0);
            dmem   = ($urandom_range(3) == 0);
            en_e   = 1'($urandom_range(1));
            en_m   = 1'($urandom_range(1));
            en_w   = 1'($urandom_range(1));
            rs1_d  = 5'($urandom_range(7));
            rs2_d  = 5'($urandom_range(7));
            rs1_e  = 5'($urandom_range(7));
            rs2_e  = 5'($urandom_range(7));
            rd_e   = 5'($urandom_range(7));
            rd_m   = 5'($urandom_range(7));
            rd_w   = 5'($urandom_range(7));
            tick();
        end
        clear();
        reset = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
